uart_frame_rx: RTL and testbench
================================

UART_FRAME_RX -- requirements
Module: uart_frame_rx

Interface
REQ-001 Parameter MAX_LEN, default 16, SHALL set the maximum payload length in bytes (legal range 1..255).
REQ-002 Parameter HEADER, default 8'hA5, SHALL set the frame start byte.
REQ-003 Parameter TIMEOUT_CYC, default 50000, SHALL set the inter-byte timeout in sclk cycles (1 ms at 50 MHz).
REQ-004 sclk  input  1  SHALL be the single clock; all logic is rising-edge.
REQ-005 s_rst  input  1  SHALL be the synchronous, active-high reset.
REQ-006 rx_data  input  8  SHALL carry the received byte from uart_rx.
REQ-007 po_flag  input  1  SHALL be a one-cycle strobe marking rx_data valid.
REQ-008 out_data  output  8  SHALL carry the payload byte being delivered.
REQ-009 out_valid  output  1  SHALL indicate that out_data is valid.
REQ-010 out_ready  input  1  SHALL indicate that the consumer accepts out_data this cycle.
REQ-011 out_last  output  1  SHALL mark the final payload byte of a frame; qualified by out_valid.
REQ-012 frame_ok  output  1  SHALL pulse for one cycle when a frame passes its checksum.
REQ-013 frame_err  output  1  SHALL pulse for one cycle on bad length, bad checksum or timeout.
REQ-014 drop  output  1  SHALL pulse for one cycle when a byte arrives during DRAIN and is discarded.

Function
REQ-015 The frame format SHALL be HEADER, LEN, LEN payload bytes, CSUM, where CSUM = (LEN + sum of payload bytes) mod 256.
REQ-016 States SHALL be IDLE, LEN, PAYLOAD, CSUM and DRAIN; the FSM SHALL act only on cycles where po_flag=1, except for the DRAIN and timeout transitions.
REQ-017 IDLE: a byte equal to HEADER SHALL go to LEN; any other byte SHALL be ignored silently.
REQ-018 LEN: LEN=0 or LEN>MAX_LEN SHALL pulse frame_err and return to IDLE; otherwise the FSM SHALL store LEN, seed the checksum with LEN and go to PAYLOAD.
REQ-019 PAYLOAD: each byte SHALL be written to buffer[wr_ptr], added to the 8-bit wrapping checksum, and wr_ptr incremented; after the LEN-th byte the FSM SHALL go to CSUM.
REQ-020 CSUM: on match, frame_ok SHALL pulse the cycle after the po_flag and the FSM SHALL enter DRAIN; on mismatch, frame_err SHALL pulse the same cycle-after and the FSM SHALL return to IDLE with the buffer discarded.
REQ-021 DRAIN: out_valid=1 and out_data=buffer[rd_ptr]; rd_ptr SHALL advance only on out_valid&out_ready; out_last=1 when rd_ptr=LEN-1; the FSM SHALL go to IDLE the cycle after the last handshake.
REQ-022 Payload bytes SHALL never appear on the output before frame_ok; out_valid SHALL be 0 in every state except DRAIN.
REQ-023 po_flag arriving in DRAIN SHALL pulse drop and SHALL NOT alter state, buffer or pointers.
REQ-024 out_data and out_last SHALL remain stable while out_valid=1 and out_ready=0.
REQ-025 A HEADER-valued byte inside LEN, PAYLOAD or CSUM SHALL be treated as data, not as a resync.

Reset
REQ-026 On s_rst=1 at a clock edge, the state SHALL become IDLE, all pointers, LEN and checksum SHALL become 0, and out_valid, out_last, frame_ok, frame_err and drop SHALL become 0; out_data SHALL become 8'h00.
REQ-027 Reset mid-frame or mid-DRAIN SHALL abandon the frame with no frame_ok or frame_err pulse.

Configuration
REQ-028 With FRAME_TIMEOUT_EN defined, a counter SHALL clear on every po_flag and count in LEN, PAYLOAD and CSUM; reaching TIMEOUT_CYC SHALL pulse frame_err and return to IDLE.
REQ-029 With FRAME_TIMEOUT_EN undefined, the counter SHALL not exist, a partial frame SHALL wait indefinitely, and the TIMEOUT_CYC parameter SHALL be ignored.

Structure
REQ-030 The shared package uart_pkg SHALL hold the FSM state encoding, HEADER default and the default MAX_LEN/TIMEOUT_CYC constants.
REQ-031 The payload buffer SHALL be a sub-module frame_buf (MAX_LEN x 8, one synchronous write port, asynchronous read port) instantiated once.

Verification
REQ-032 A5 03 11 22 33 69 with out_ready=1 -> frame_ok pulses once; out_data 11, 22, 33 with out_last on 33; frame_err never pulses.
REQ-033 A5 02 10 20 00 -> frame_err pulses once; out_valid stays 0; the next valid frame is accepted normally.
REQ-034 A5 00 and A5 11 (with MAX_LEN=16) -> frame_err pulses after the LEN byte; the FSM returns to IDLE.
REQ-035 A valid 3-byte frame with out_ready held low for 10 cycles, plus a byte injected in DRAIN -> data is held stable, drop pulses once, and all 3 bytes are delivered after out_ready rises.
REQ-036 FRAME_TIMEOUT_EN with TIMEOUT_CYC=100: A5 02 11 then silence -> frame_err pulses 100 cycles after the 11 byte; without the macro -> no pulse for 1000 cycles.
REQ-037 s_rst asserted after A5 02 11 -> all outputs are 0 the next cycle, no pulses occur, and a subsequent A5 01 7F 80 yields frame_ok and out_data 7F.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding and default constants for the UART frame receiver
//
// Package uart_pkg
//   rx_state_t      : frame parser states (IDLE, LEN, PAYLOAD, CSUM, DRAIN)
//   DEF_HEADER      : default frame start byte
//   DEF_MAX_LEN     : default maximum payload length in bytes
//   DEF_TIMEOUT_CYC : default inter-byte timeout in sclk cycles (1 ms at 50 MHz)
//   csum_add()      : 8-bit wrapping checksum accumulate
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CSUM    = 3'd3,
        ST_DRAIN   = 3'd4
    } rx_state_t;

    localparam logic [7:0] DEF_HEADER      = 8'hA5;
    localparam int         DEF_MAX_LEN     = 16;
    localparam int         DEF_TIMEOUT_CYC = 50000;

    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

endpackage

// File: rtl/frame_buf.sv
// rtl/frame_buf.sv - payload byte store, one synchronous write port and one asynchronous read port
//
// Parameters
//   DEPTH   : number of bytes stored
//   AW      : address width
// Ports
//   clk     : rising-edge clock
//   wr_en   : write strobe
//   wr_addr : write address
//   wr_data : write byte
//   rd_addr : read address (combinational read)
//   rd_data : byte at rd_addr
module frame_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_frame_rx.sv
// rtl/uart_frame_rx.sv - parses HEADER/LEN/payload/CSUM frames from a UART byte stream and streams checked payloads out
//
// Optional feature macro: FRAME_TIMEOUT_EN (inter-byte timeout while a frame is in progress)
//
// Parameters
//   MAX_LEN     : maximum payload length in bytes (1..255)
//   HEADER      : frame start byte
//   TIMEOUT_CYC : inter-byte timeout in sclk cycles, used only with FRAME_TIMEOUT_EN
// Ports
//   sclk      : clock, rising edge
//   s_rst     : synchronous active-high reset
//   rx_data   : received byte
//   po_flag   : one-cycle strobe, rx_data valid
//   out_data  : payload byte being delivered
//   out_valid : out_data valid (only while draining a checked frame)
//   out_ready : consumer accepts out_data this cycle
//   out_last  : final payload byte of the frame
//   frame_ok  : one-cycle pulse, checksum matched
//   frame_err : one-cycle pulse, bad length, bad checksum or timeout
//   drop      : one-cycle pulse, byte discarded while draining
module uart_frame_rx
    import uart_pkg::*;
#(
    parameter int         MAX_LEN     = DEF_MAX_LEN,
    parameter logic [7:0] HEADER      = DEF_HEADER,
    parameter int         TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic       sclk,
    input  logic       s_rst,
    input  logic [7:0] rx_data,
    input  logic       po_flag,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       frame_ok,
    output logic       frame_err,
    output logic       drop
);

    localparam int         AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    rx_state_t  state;
    logic [7:0] len;
    logic [7:0] csum;
    logic [7:0] wr_ptr;
    logic [7:0] rd_ptr;
    logic [7:0] rd_nxt;

    logic          buf_we;
    logic [AW-1:0] buf_raddr;
    logic [7:0]    buf_rdata;

    // The read port looks one byte ahead so out_data can be registered:
    // entering DRAIN loads byte 0, each handshake loads byte rd_ptr+1.
    assign rd_nxt = rd_ptr + 8'd1;
    assign buf_we = po_flag && (state == ST_PAYLOAD);

    always_comb begin
        buf_raddr = '0;
        if (state != ST_CSUM && rd_nxt < MAX_LEN_B) begin
            buf_raddr = rd_nxt[AW-1:0];
        end
    end

    frame_buf #(
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_frame_buf (
        .clk     (sclk),
        .wr_en   (buf_we),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data (rx_data),
        .rd_addr (buf_raddr),
        .rd_data (buf_rdata)
    );

`ifdef FRAME_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             in_frame;
    logic             timeout_hit;

    assign in_frame = (state == ST_LEN) || (state == ST_PAYLOAD) || (state == ST_CSUM);

    // Fires on the edge where the count would reach TIMEOUT_CYC, so frame_err
    // shows up exactly TIMEOUT_CYC cycles after the last accepted byte.
    always_comb begin
        timeout_hit = 1'b0;
        if (in_frame && !po_flag && tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
            timeout_hit = 1'b1;
        end
    end
`endif

    always_ff @(posedge sclk) begin
        if (s_rst) begin
            state     <= ST_IDLE;
            len       <= 8'd0;
            csum      <= 8'd0;
            wr_ptr    <= 8'd0;
            rd_ptr    <= 8'd0;
            out_data  <= 8'h00;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            drop      <= 1'b0;
`ifdef FRAME_TIMEOUT_EN
            tmo_cnt   <= '0;
`endif
        end else begin
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            drop      <= 1'b0;

`ifdef FRAME_TIMEOUT_EN
            if (po_flag || !in_frame) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
`endif

            case (state)
                ST_IDLE: begin
                    if (po_flag && rx_data == HEADER) begin
                        state <= ST_LEN;
                    end
                end

                ST_LEN: begin
                    if (po_flag) begin
                        if (rx_data == 8'd0 || rx_data > MAX_LEN_B) begin
                            frame_err <= 1'b1;
                            state     <= ST_IDLE;
                        end else begin
                            len    <= rx_data;
                            csum   <= rx_data;
                            wr_ptr <= 8'd0;
                            state  <= ST_PAYLOAD;
                        end
                    end
                end

                ST_PAYLOAD: begin
                    if (po_flag) begin
                        csum   <= csum_add(csum, rx_data);
                        wr_ptr <= wr_ptr + 8'd1;
                        if (wr_ptr == len - 8'd1) begin
                            state <= ST_CSUM;
                        end
                    end
                end

                ST_CSUM: begin
                    if (po_flag) begin
                        if (rx_data == csum) begin
                            frame_ok  <= 1'b1;
                            state     <= ST_DRAIN;
                            rd_ptr    <= 8'd0;
                            out_valid <= 1'b1;
                            out_data  <= buf_rdata;
                            out_last  <= (len == 8'd1);
                        end else begin
                            frame_err <= 1'b1;
                            state     <= ST_IDLE;
                        end
                    end
                end

                ST_DRAIN: begin
                    // Incoming bytes are discarded here; the drain itself
                    // is paced only by the consumer.
                    if (po_flag) begin
                        drop <= 1'b1;
                    end
                    if (out_ready) begin
                        if (out_last) begin
                            state     <= ST_IDLE;
                            rd_ptr    <= 8'd0;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            out_data  <= 8'h00;
                        end else begin
                            rd_ptr   <= rd_nxt;
                            out_data <= buf_rdata;
                            out_last <= (rd_nxt == len - 8'd1);
                        end
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase

`ifdef FRAME_TIMEOUT_EN
            if (timeout_hit) begin
                frame_err <= 1'b1;
                state     <= ST_IDLE;
            end
`endif
        end
    end

endmodule

// File: tb/tb_uart_frame_rx.sv
// tb/tb_uart_frame_rx.sv - self-checking bench for uart_frame_rx
module tb_uart_frame_rx;

    logic       sclk = 1'b0;
    logic       s_rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       po_flag = 1'b0;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_last;
    logic       frame_ok;
    logic       frame_err;
    logic       drop;

    int total = 0;
    int bad   = 0;

    int ok_cnt    = 0;
    int err_cnt   = 0;
    int drop_cnt  = 0;
    int valid_cyc = 0;
    int stab_err  = 0;
    logic [7:0] got_q[$];
    bit         last_q[$];
    bit         hold_p = 1'b0;
    logic [7:0] hold_d = 8'h00;
    logic       hold_l = 1'b0;

    always #5 sclk = ~sclk;

    uart_frame_rx #(
        .MAX_LEN     (16),
        .HEADER      (8'hA5),
        .TIMEOUT_CYC (100)
    ) dut (
        .sclk      (sclk),
        .s_rst     (s_rst),
        .rx_data   (rx_data),
        .po_flag   (po_flag),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .frame_ok  (frame_ok),
        .frame_err (frame_err),
        .drop      (drop)
    );

    // Observer: pulse counters, handshake capture and hold-stability tracking.
    always @(negedge sclk) begin
        if (frame_ok === 1'b1)  ok_cnt++;
        if (frame_err === 1'b1) err_cnt++;
        if (drop === 1'b1)      drop_cnt++;
        if (out_valid === 1'b1) valid_cyc++;
        if (hold_p && (out_valid !== 1'b1 || out_data !== hold_d || out_last !== hold_l)) stab_err++;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            got_q.push_back(out_data);
            last_q.push_back(out_last);
        end
        hold_p = (out_valid === 1'b1) && (out_ready === 1'b0);
        hold_d = out_data;
        hold_l = out_last;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got=running exp=finished");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        po_flag = 1'b1;
        tick();
        po_flag = 1'b0;
        rx_data = 8'($urandom);
    endtask

    task automatic gap(input int n);
        repeat (n) tick();
    endtask

    task automatic drain_wait(input bit rand_rdy, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < 500; i++) begin
            if (out_valid !== 1'b1) begin
                timed_out = 1'b0;
                break;
            end
            out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
        end
        out_ready = 1'b1;
    endtask

    // Reference: walks a byte stream by the frame rules and lists the payload
    // bytes that must be delivered plus the number of good and bad frames.
    function automatic void ref_model(input logic [7:0] s[$], output logic [7:0] pay[$],
                                      output bit lst[$], output int n_ok, output int n_err);
        int i = 0;
        pay = {};
        lst = {};
        n_ok = 0;
        n_err = 0;
        while (i < s.size()) begin
            if (s[i] != 8'hA5) begin
                i++;
            end else if (i + 1 >= s.size()) begin
                break;
            end else begin
                int l = int'(s[i+1]);
                if (l == 0 || l > 16) begin
                    n_err++;
                    i += 2;
                end else if (i + 2 + l >= s.size()) begin
                    break;
                end else begin
                    int sum = l;
                    for (int k = 0; k < l; k++) sum += int'(s[i+2+k]);
                    if (int'(s[i+2+l]) == sum % 256) begin
                        n_ok++;
                        for (int k = 0; k < l; k++) begin
                            pay.push_back(s[i+2+k]);
                            lst.push_back(k == l - 1);
                        end
                    end else begin
                        n_err++;
                    end
                    i += 3 + l;
                end
            end
        end
    endfunction

    task automatic test_reset();
        s_rst = 1'b1;
        gap(3);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (out_last !== 1'b0)  begin bad++; $display("FAIL reset_out_last got=%b exp=0", out_last); end
        total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
        total++; if (frame_ok !== 1'b0)  begin bad++; $display("FAIL reset_frame_ok got=%b exp=0", frame_ok); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
        total++; if (drop !== 1'b0)      begin bad++; $display("FAIL reset_drop got=%b exp=0", drop); end
        s_rst = 1'b0;
        gap(2);
    endtask

    task automatic test_good_frame();
        logic [7:0] fr[6] = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
        logic [7:0] exp_d[3] = '{8'h11, 8'h22, 8'h33};
        int ok0 = ok_cnt, err0 = err_cnt;
        bit to;
        got_q = {}; last_q = {};
        for (int i = 0; i < 6; i++) begin
            send_byte(fr[i]);
            if (i == 5) begin
                total++; if (frame_ok !== 1'b1) begin bad++; $display("FAIL good_ok_timing got=%b exp=1", frame_ok); end
                total++; if (out_data !== 8'h11) begin bad++; $display("FAIL good_first_data got=%h exp=11", out_data); end
            end else begin
                gap(1);
            end
        end
        drain_wait(1'b0, to);
        gap(2);
        total++; if (to) begin bad++; $display("FAIL good_drain_timeout got=1 exp=0"); end
        total++; if (ok_cnt - ok0 != 1) begin bad++; $display("FAIL good_ok_count got=%0d exp=1", ok_cnt - ok0); end
        total++; if (err_cnt != err0) begin bad++; $display("FAIL good_err_count got=%0d exp=0", err_cnt - err0); end
        total++; if (got_q.size() != 3) begin bad++; $display("FAIL good_len got=%0d exp=3", got_q.size()); end
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            total++; if (got_q[i] !== exp_d[i]) begin bad++; $display("FAIL good_data[%0d] got=%h exp=%h", i, got_q[i], exp_d[i]); end
            total++; if (last_q[i] !== (i == 2)) begin bad++; $display("FAIL good_last[%0d] got=%b exp=%b", i, last_q[i], i == 2); end
        end
    endtask

    task automatic test_bad_csum();
        logic [7:0] fr[5] = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h00};
        int err0 = err_cnt, ok0 = ok_cnt, v0 = valid_cyc;
        bit to;
        for (int i = 0; i < 5; i++) send_byte(fr[i]);
        total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL badcs_err_timing got=%b exp=1", frame_err); end
        gap(3);
        total++; if (err_cnt - err0 != 1) begin bad++; $display("FAIL badcs_err_count got=%0d exp=1", err_cnt - err0); end
        total++; if (ok_cnt != ok0) begin bad++; $display("FAIL badcs_ok_count got=%0d exp=0", ok_cnt - ok0); end
        total++; if (valid_cyc != v0) begin bad++; $display("FAIL badcs_out_valid got=%0d exp=0", valid_cyc - v0); end
        got_q = {};
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7F); send_byte(8'h80);
        total++; if (frame_ok !== 1'b1) begin bad++; $display("FAIL badcs_next_ok got=%b exp=1", frame_ok); end
        drain_wait(1'b0, to);
        gap(1);
        total++; if (got_q.size() != 1 || got_q[0] !== 8'h7F) begin bad++; $display("FAIL badcs_next_data got_size=%0d exp=1 byte 7f", got_q.size()); end
    endtask

    task automatic test_bad_len();
        logic [7:0] lens[2] = '{8'h00, 8'h11};
        int ok0;
        bit to;
        for (int i = 0; i < 2; i++) begin
            int err0 = err_cnt;
            send_byte(8'hA5);
            send_byte(lens[i]);
            total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL badlen_%h_timing got=%b exp=1", lens[i], frame_err); end
            gap(2);
            total++; if (err_cnt - err0 != 1) begin bad++; $display("FAIL badlen_%h_count got=%0d exp=1", lens[i], err_cnt - err0); end
        end
        ok0 = ok_cnt;
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h55); send_byte(8'h56);
        drain_wait(1'b0, to);
        gap(1);
        total++; if (ok_cnt - ok0 != 1) begin bad++; $display("FAIL badlen_recover got=%0d exp=1", ok_cnt - ok0); end
    endtask

    task automatic test_backpressure();
        logic [7:0] fr[6] = '{8'hA5, 8'h03, 8'hA5, 8'h01, 8'h02, 8'hAB};
        logic [7:0] exp_d[3] = '{8'hA5, 8'h01, 8'h02};
        int ok0 = ok_cnt, d0 = drop_cnt, s0 = stab_err;
        bit to;
        got_q = {}; last_q = {};
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) send_byte(fr[i]);
        total++; if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_last !== 1'b0) begin
            bad++; $display("FAIL bp_first got=v%b d%h l%b exp=v1 dA5 l0", out_valid, out_data, out_last); end
        for (int c = 0; c < 10; c++) begin
            if (c == 4) begin
                send_byte(8'hA5);
                total++; if (drop !== 1'b1) begin bad++; $display("FAIL bp_drop_pulse got=%b exp=1", drop); end
            end else begin
                tick();
            end
        end
        total++; if (drop_cnt - d0 != 1) begin bad++; $display("FAIL bp_drop_count got=%0d exp=1", drop_cnt - d0); end
        total++; if (out_data !== 8'hA5 || out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold got=v%b d%h exp=v1 dA5", out_valid, out_data); end
        total++; if (got_q.size() != 0) begin bad++; $display("FAIL bp_early got=%0d exp=0", got_q.size()); end
        drain_wait(1'b0, to);
        gap(2);
        total++; if (to) begin bad++; $display("FAIL bp_drain_timeout got=1 exp=0"); end
        total++; if (stab_err != s0) begin bad++; $display("FAIL bp_stability got=%0d exp=0", stab_err - s0); end
        total++; if (ok_cnt - ok0 != 1) begin bad++; $display("FAIL bp_ok_count got=%0d exp=1", ok_cnt - ok0); end
        total++; if (got_q.size() != 3) begin bad++; $display("FAIL bp_len got=%0d exp=3", got_q.size()); end
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            total++; if (got_q[i] !== exp_d[i] || last_q[i] !== (i == 2)) begin
                bad++; $display("FAIL bp_data[%0d] got=%h/%b exp=%h/%b", i, got_q[i], last_q[i], exp_d[i], i == 2); end
        end
    endtask

    task automatic test_timeout();
        int first = 0, pulses = 0;
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h11);
        for (int n = 1; n <= 1000; n++) begin
            tick();
            if (frame_err === 1'b1) begin
                pulses++;
                if (first == 0) first = n;
            end
        end
`ifdef FRAME_TIMEOUT_EN
        total++; if (first != 100) begin bad++; $display("FAIL timeout_delay got=%0d exp=100", first); end
        total++; if (pulses != 1) begin bad++; $display("FAIL timeout_pulses got=%0d exp=1", pulses); end
`else
        total++; if (pulses != 0) begin bad++; $display("FAIL timeout_absent got=%0d exp=0 (first=%0d)", pulses, first); end
`endif
    endtask

    task automatic test_reset_midframe();
        int ok0, err0;
        bit to;
        s_rst = 1'b1; tick(); s_rst = 1'b0; gap(2);
        ok0 = ok_cnt; err0 = err_cnt;
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h11);
        tick();
        s_rst = 1'b1;
        tick();
        s_rst = 1'b0;
        total++; if ({out_valid, out_last, frame_ok, frame_err, drop} !== 5'b0 || out_data !== 8'h00) begin
            bad++; $display("FAIL rstmid_outputs got=v%b l%b ok%b er%b dr%b d%h exp=all0",
                            out_valid, out_last, frame_ok, frame_err, drop, out_data); end
        gap(3);
        total++; if (ok_cnt != ok0 || err_cnt != err0) begin
            bad++; $display("FAIL rstmid_pulses got=ok%0d err%0d exp=0/0", ok_cnt - ok0, err_cnt - err0); end
        got_q = {};
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7F); send_byte(8'h80);
        total++; if (frame_ok !== 1'b1 || out_data !== 8'h7F) begin bad++; $display("FAIL rstmid_next got=ok%b d%h exp=ok1 d7f", frame_ok, out_data); end
        drain_wait(1'b0, to);
        gap(1);
        total++; if (got_q.size() != 1) begin bad++; $display("FAIL rstmid_next_len got=%0d exp=1", got_q.size()); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 25; it++) begin
            logic [7:0] s[$];
            logic [7:0] pay[$];
            bit lst[$];
            int eok, eerr, ok0, err0, kind, l, sum;
            bit to;
            s = {};
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
                logic [7:0] b = 8'($urandom);
                s.push_back(b == 8'hA5 ? 8'h5A : b);
            end
            kind = int'($urandom_range(0, 3));
            s.push_back(8'hA5);
            if (kind == 3) begin
                s.push_back($urandom_range(0, 1) ? 8'h00 : 8'($urandom_range(17, 255)));
            end else begin
                l = int'($urandom_range(1, 16));
                s.push_back(8'(l));
                sum = l;
                for (int k = 0; k < l; k++) begin
                    logic [7:0] p = (it == 0 && k == 0) ? 8'hA5 : 8'($urandom);
                    s.push_back(p);
                    sum += int'(p);
                end
                if (kind == 2) s.push_back(8'(sum % 256) ^ 8'($urandom_range(1, 255)));
                else           s.push_back(8'(sum % 256));
            end
            ref_model(s, pay, lst, eok, eerr);
            got_q = {}; last_q = {};
            ok0 = ok_cnt; err0 = err_cnt;
            foreach (s[i]) begin
                send_byte(s[i]);
                if (i != s.size() - 1) gap(int'($urandom_range(0, 2)));
            end
            drain_wait(1'b1, to);
            gap(2);
            total++; if (to) begin bad++; $display("FAIL rand%0d_drain_timeout got=1 exp=0", it); end
            total++; if (ok_cnt - ok0 != eok) begin bad++; $display("FAIL rand%0d_ok got=%0d exp=%0d", it, ok_cnt - ok0, eok); end
            total++; if (err_cnt - err0 != eerr) begin bad++; $display("FAIL rand%0d_err got=%0d exp=%0d", it, err_cnt - err0, eerr); end
            total++; if (got_q.size() != pay.size()) begin bad++; $display("FAIL rand%0d_len got=%0d exp=%0d", it, got_q.size(), pay.size()); end
            for (int i = 0; i < pay.size() && i < got_q.size(); i++) begin
                total++; if (got_q[i] !== pay[i] || last_q[i] !== lst[i]) begin
                    bad++; $display("FAIL rand%0d_data[%0d] got=%h/%b exp=%h/%b", it, i, got_q[i], last_q[i], pay[i], lst[i]); end
            end
        end
        total++; if (stab_err != 0) begin bad++; $display("FAIL rand_stability got=%0d exp=0", stab_err); end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_csum();
        test_bad_len();
        test_backpressure();
        test_timeout();
        test_reset_midframe();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
